// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the pipelined MIPS core.
//   - ALU control codes driven to the EX-stage ALU.
//   - R-type funct field encodings.
//   - ALUop encodings produced by the main decoder.
//   - Operand forwarding source select.
package mips_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd15;  // ALU outputs 0

  // R-type funct encodings
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALUop encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  // Forwarding source for an ALU operand
  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/mips_alu_ctrl.sv
// mips_alu_ctrl: combinational ALU control decoder.
// Ports:
//   i_aluop   - 2-bit ALUop from the main decoder
//   i_funct   - 6-bit R-type funct field
//   o_aluctrl - 4-bit ALU control code (ALU_NOP for unsupported funct)
//   o_illegal - R-type with an unsupported funct (not gated by instruction validity)
module mips_alu_ctrl
  import mips_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_aluctrl,
  output logic       o_illegal
);

  always_comb begin
    o_aluctrl = ALU_NOP;
    o_illegal = 1'b0;
    unique case (i_aluop)
      ALUOP_ADD: o_aluctrl = ALU_ADD;
      ALUOP_SUB: o_aluctrl = ALU_SUB;
      ALUOP_ORI: o_aluctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_aluctrl = ALU_ADD;
          FUNCT_SUB: o_aluctrl = ALU_SUB;
          FUNCT_AND: o_aluctrl = ALU_AND;
          FUNCT_OR:  o_aluctrl = ALU_OR;
          FUNCT_NOR: o_aluctrl = ALU_NOR;
          FUNCT_SLT: o_aluctrl = ALU_SLT;
          FUNCT_SLL: o_aluctrl = ALU_SLL;
          default: begin
            o_aluctrl = ALU_NOP;
            o_illegal = 1'b1;
          end
        endcase
      end
      default: o_aluctrl = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mips_id_ex_stage.sv
// mips_id_ex_stage: ID/EX pipeline register feeding the EX-stage ALU.
// Registers decoded operands/control each cycle (priority rst > flush > stall > load),
// decodes ALUop/funct to the ALU control code, and forwards EX/MEM and MEM/WB results
// into the ALU operands.
// Build option: define IDEX_FORWARD_EN to enable forwarding; without it the operands
// always come from the registered register-file data and exmem_*/memwb_* are ignored.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   stall, flush                 - hold contents / load a bubble
//   id_*                         - decoded ID-stage instruction fields and control
//   exmem_*, memwb_*             - forwarding sources
//   ex_valid, ex_aluctrl         - EX instruction valid, ALU control code
//   ex_in1, ex_in2, ex_store_data- ALU operands and forwarded store data
//   ex_dest                      - destination register index
//   ex_regwrite..ex_branch       - registered control bits
//   ex_illegal                   - unsupported R-type funct
module mips_id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_funct,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_branch,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [3:0]    ex_aluctrl,
  output logic [DW-1:0] ex_in1,
  output logic [DW-1:0] ex_in2,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_branch,
  output logic          ex_illegal
);

  // Decode
  logic [3:0] w_dec_aluctrl;
  logic       w_dec_illegal;

  mips_alu_ctrl u_alu_ctrl (
    .i_aluop   (id_aluop),
    .i_funct   (id_funct),
    .o_aluctrl (w_dec_aluctrl),
    .o_illegal (w_dec_illegal)
  );

  // An invalid ID slot loads as a bubble: no control effects, NOP ALU code.
  logic [3:0] w_ld_aluctrl;
  logic       w_ld_illegal;
  logic [4:0] w_ld_ctl;

  always_comb begin
    w_ld_aluctrl = id_valid ? w_dec_aluctrl : ALU_NOP;
    w_ld_illegal = id_valid & w_dec_illegal;
    w_ld_ctl     = {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch}
                   & {5{id_valid}};
  end

  // ID/EX registers
  logic          r_valid;
  logic [3:0]    r_aluctrl;
  logic          r_illegal;
  logic [4:0]    r_ctl;  // {regwrite, memread, memwrite, memtoreg, branch}
  logic [RW-1:0] r_dest;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm;
  logic          r_alusrc;
  logic [4:0]    r_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_aluctrl <= ALU_NOP;
      r_illegal <= 1'b0;
      r_ctl     <= '0;
      r_dest    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_alusrc  <= 1'b0;
      r_shamt   <= '0;
    end else if (flush) begin
      // Bubble is the reset state; flush wins over stall.
      r_valid   <= 1'b0;
      r_aluctrl <= ALU_NOP;
      r_illegal <= 1'b0;
      r_ctl     <= '0;
      r_dest    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_alusrc  <= 1'b0;
      r_shamt   <= '0;
    end else if (!stall) begin
      r_valid   <= id_valid;
      r_aluctrl <= w_ld_aluctrl;
      r_illegal <= w_ld_illegal;
      r_ctl     <= w_ld_ctl;
      r_dest    <= id_regdst ? id_rd : id_rt;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_alusrc  <= id_alusrc;
      r_shamt   <= id_shamt;
    end
  end

  // Forwarding select: EX/MEM is the younger result so it wins; r0 never forwards.
  fwd_sel_e w_fwd_a_sel;
  fwd_sel_e w_fwd_b_sel;

  always_comb begin
    w_fwd_a_sel = FWD_REG;
    w_fwd_b_sel = FWD_REG;
`ifdef IDEX_FORWARD_EN
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs)) begin
      w_fwd_a_sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs)) begin
      w_fwd_a_sel = FWD_MEMWB;
    end
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rt)) begin
      w_fwd_b_sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rt)) begin
      w_fwd_b_sel = FWD_MEMWB;
    end
`endif
  end

`ifndef IDEX_FORWARD_EN
  // Forwarding ports stay on the interface but have no function in this build.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result};
`endif

  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;
  logic [DW-1:0] w_shamt_ext;

  always_comb begin
    w_fwd_a = r_rs_data;
    w_fwd_b = r_rt_data;
    case (w_fwd_a_sel)
      FWD_EXMEM: w_fwd_a = exmem_result;
      FWD_MEMWB: w_fwd_a = memwb_result;
      default:   w_fwd_a = r_rs_data;
    endcase
    case (w_fwd_b_sel)
      FWD_EXMEM: w_fwd_b = exmem_result;
      FWD_MEMWB: w_fwd_b = memwb_result;
      default:   w_fwd_b = r_rt_data;
    endcase
    w_shamt_ext = {{(DW-5){1'b0}}, r_shamt};
  end

  // Operand muxing: SLL shifts rt by shamt, so rt goes to in1.
  always_comb begin
    if (r_aluctrl == ALU_SLL) begin
      ex_in1 = w_fwd_b;
      ex_in2 = w_shamt_ext;
    end else begin
      ex_in1 = w_fwd_a;
      ex_in2 = r_alusrc ? r_imm : w_fwd_b;
    end
    ex_store_data = w_fwd_b;
  end

  assign ex_valid    = r_valid;
  assign ex_aluctrl  = r_aluctrl;
  assign ex_illegal  = r_illegal;
  assign ex_dest     = r_dest;
  assign ex_regwrite = r_ctl[4];
  assign ex_memread  = r_ctl[3];
  assign ex_memwrite = r_ctl[2];
  assign ex_memtoreg = r_ctl[1];
  assign ex_branch   = r_ctl[0];

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// tb_mips_id_ex_stage: self-checking bench for mips_id_ex_stage.
// Expected EX state is pushed to a scoreboard queue when ID stimulus is driven and
// compared one clock later. Expected forwarding results follow IDEX_FORWARD_EN.
module tb_mips_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

`ifdef IDEX_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall, flush, id_valid;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic [4:0]    id_shamt;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          id_alusrc, id_regdst;
  logic          id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
  logic          exmem_regwrite, memwb_regwrite;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic          ex_valid, ex_illegal;
  logic [3:0]    ex_aluctrl;
  logic [DW-1:0] ex_in1, ex_in2, ex_store_data;
  logic [RW-1:0] ex_dest;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;

  mips_id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_aluop       (id_aluop),
    .id_funct       (id_funct),
    .id_shamt       (id_shamt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_alusrc      (id_alusrc),
    .id_regdst      (id_regdst),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .id_memwrite    (id_memwrite),
    .id_memtoreg    (id_memtoreg),
    .id_branch      (id_branch),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .ex_valid       (ex_valid),
    .ex_aluctrl     (ex_aluctrl),
    .ex_in1         (ex_in1),
    .ex_in2         (ex_in2),
    .ex_store_data  (ex_store_data),
    .ex_dest        (ex_dest),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_memtoreg    (ex_memtoreg),
    .ex_branch      (ex_branch),
    .ex_illegal     (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       valid;
    logic [3:0] ctrl;
    logic       ill;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] st;
    logic [4:0] dest;
    logic [4:0] ctl;  // {regwrite, memread, memwrite, memtoreg, branch}
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_next(input string tag, input logic v, input logic [3:0] ctrl,
                             input logic ill, input logic [31:0] in1, input logic [31:0] in2,
                             input logic [31:0] st, input logic [4:0] dest,
                             input logic [4:0] ctl);
    exp_t e;
    e.tag = tag; e.valid = v; e.ctrl = ctrl; e.ill = ill;
    e.in1 = in1; e.in2 = in2; e.st = st; e.dest = dest; e.ctl = ctl;
    q.push_back(e);
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.tag, ".valid"},   32'(ex_valid),      32'(e.valid));
    chk({e.tag, ".aluctrl"}, 32'(ex_aluctrl),    32'(e.ctrl));
    chk({e.tag, ".illegal"}, 32'(ex_illegal),    32'(e.ill));
    chk({e.tag, ".in1"},     ex_in1,             e.in1);
    chk({e.tag, ".in2"},     ex_in2,             e.in2);
    chk({e.tag, ".store"},   ex_store_data,      e.st);
    chk({e.tag, ".dest"},    32'(ex_dest),       32'(e.dest));
    chk({e.tag, ".ctl"},
        32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}), 32'(e.ctl));
  endtask

  // Clock the stage and compare against the oldest pending expectation.
  task automatic tick_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    chk("sb_pending", 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check_outputs(e);
    end
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_aluop = 2'b00; id_funct = 6'h00; id_shamt = 5'd0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_alusrc = 1'b0; id_regdst = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    id_memtoreg = 1'b0; id_branch = 1'b0;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic set_ctl(input logic [4:0] c);
    {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch} = c;
  endtask

  logic [5:0] functs [8];
  logic [3:0] ctrls  [8];

  initial begin
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h3F};
    ctrls  = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7, 4'd3, 4'd15};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    clear_id();
    clear_fwd();
    #12;
    chk("reset.valid",   32'(ex_valid),   32'd0);
    chk("reset.aluctrl", 32'(ex_aluctrl), 32'd15);
    chk("reset.in1",     ex_in1,          32'd0);
    chk("reset.dest",    32'(ex_dest),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type decode sweep
    for (int i = 0; i < 8; i++) begin
      logic [4:0]  c;
      logic [31:0] e1, e2;
      clear_id();
      id_valid = 1'b1; id_aluop = 2'b10; id_funct = functs[i]; id_shamt = 5'(i + 1);
      id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_regdst = 1'b1;
      id_rs_data = 32'(100 + i); id_rt_data = 32'(200 + i);
      c = {1'b1, i[0], i[1], i[2], i[0] ^ i[1]};
      set_ctl(c);
      e1 = (functs[i] == 6'h00) ? id_rt_data : id_rs_data;
      e2 = (functs[i] == 6'h00) ? 32'(i + 1) : id_rt_data;
      expect_next($sformatf("rtype_%0h", functs[i]), 1'b1, ctrls[i], functs[i] == 6'h3F,
                  e1, e2, id_rt_data, 5'd3, c);
      tick_and_check();
    end

    // Invalid slot with illegal funct loads as a bubble; data and dest still load.
    clear_id();
    id_aluop = 2'b10; id_funct = 6'h3F; id_rs_data = 32'h55; id_rt_data = 32'h66;
    id_rt = 5'd9; id_rd = 5'd4; set_ctl(5'b11111);
    expect_next("invalid", 1'b0, 4'd15, 1'b0, 32'h55, 32'h66, 32'h66, 5'd9, 5'b00000);
    tick_and_check();

    // SUB and ORI decodes
    clear_id();
    id_valid = 1'b1; id_aluop = 2'b01; id_rs_data = 32'd40; id_rt_data = 32'd2;
    id_rt = 5'd6; set_ctl(5'b00001);
    expect_next("sub", 1'b1, 4'd6, 1'b0, 32'd40, 32'd2, 32'd2, 5'd6, 5'b00001);
    tick_and_check();
    id_aluop = 2'b11; id_alusrc = 1'b1; id_imm = 32'h0000_F0F0; set_ctl(5'b10000);
    expect_next("ori", 1'b1, 4'd1, 1'b0, 32'd40, 32'h0000_F0F0, 32'd2, 5'd6, 5'b10000);
    tick_and_check();

    // Forwarding priority on operand A
    clear_id();
    id_valid = 1'b1; id_rs = 5'd8; id_rt = 5'd4; id_rs_data = 32'd5; id_rt_data = 32'd6;
    set_ctl(5'b10000);
    exmem_regwrite = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h22;
    expect_next("fwdA_exmem", 1'b1, 4'd2, 1'b0, Fwd ? 32'h11 : 32'd5, 32'd6, 32'd6, 5'd4,
                5'b10000);
    tick_and_check();
    exmem_regwrite = 1'b0;
    expect_next("fwdA_memwb", 1'b1, 4'd2, 1'b0, Fwd ? 32'h22 : 32'd5, 32'd6, 32'd6, 5'd4,
                5'b10000);
    tick_and_check();
    id_rs = 5'd0; exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    expect_next("fwdA_r0", 1'b1, 4'd2, 1'b0, 32'd5, 32'd6, 32'd6, 5'd4, 5'b10000);
    tick_and_check();

    // Forwarding on operand B / store data
    id_rs = 5'd8; id_rt = 5'd9; id_rt_data = 32'd7; id_alusrc = 1'b1; id_imm = 32'h100;
    set_ctl(5'b00100);
    exmem_regwrite = 1'b0; exmem_rd = 5'd9; exmem_result = 32'h44;
    memwb_regwrite = 1'b1; memwb_rd = 5'd9; memwb_result = 32'h33;
    expect_next("fwdB_memwb", 1'b1, 4'd2, 1'b0, 32'd5, 32'h100, Fwd ? 32'h33 : 32'd7, 5'd9,
                5'b00100);
    tick_and_check();
    id_alusrc = 1'b0; exmem_regwrite = 1'b1;
    expect_next("fwdB_exmem", 1'b1, 4'd2, 1'b0, 32'd5, Fwd ? 32'h44 : 32'd7,
                Fwd ? 32'h44 : 32'd7, 5'd9, 5'b00100);
    tick_and_check();
    clear_fwd();

    // Stall holds, then flush (with stall) inserts a bubble
    clear_id();
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd5; id_regdst = 1'b1;
    id_rs_data = 32'd8; id_rt_data = 32'd10; set_ctl(5'b10000);
    expect_next("add", 1'b1, 4'd2, 1'b0, 32'd8, 32'd10, 32'd10, 5'd5, 5'b10000);
    tick_and_check();
    stall = 1'b1;
    id_valid = 1'b0; id_aluop = 2'b01; id_rd = 5'd6; id_rs_data = 32'd77; id_rt_data = 32'd88;
    for (int i = 0; i < 2; i++) begin
      expect_next($sformatf("stall_%0d", i), 1'b1, 4'd2, 1'b0, 32'd8, 32'd10, 32'd10, 5'd5,
                  5'b10000);
      tick_and_check();
    end
    flush = 1'b1;
    expect_next("flush", 1'b0, 4'd15, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
    tick_and_check();
    stall = 1'b0; flush = 1'b0;

    // SLL operand routing, then immediate operand
    clear_id();
    id_valid = 1'b1; id_aluop = 2'b10; id_funct = 6'h00; id_shamt = 5'd5;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd7; id_regdst = 1'b1;
    id_rs_data = 32'd99; id_rt_data = 32'd5; set_ctl(5'b10000);
    expect_next("sll", 1'b1, 4'd3, 1'b0, 32'd5, 32'd5, 32'd5, 5'd7, 5'b10000);
    tick_and_check();
    clear_id();
    id_valid = 1'b1; id_aluop = 2'b00; id_alusrc = 1'b1; id_imm = 32'hFFFF_FFFC;
    id_rt = 5'd2; id_rs_data = 32'd3; id_rt_data = 32'd9; set_ctl(5'b01010);
    expect_next("imm", 1'b1, 4'd2, 1'b0, 32'd3, 32'hFFFF_FFFC, 32'd9, 5'd2, 5'b01010);
    tick_and_check();

    // Asynchronous reset mid-cycle
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst.valid",   32'(ex_valid),   32'd0);
    chk("async_rst.aluctrl", 32'(ex_aluctrl), 32'd15);
    chk("async_rst.illegal", 32'(ex_illegal), 32'd0);
    chk("async_rst.in1",     ex_in1,          32'd0);
    chk("async_rst.in2",     ex_in2,          32'd0);
    chk("async_rst.store",   ex_store_data,   32'd0);
    chk("async_rst.dest",    32'(ex_dest),    32'd0);
    chk("async_rst.ctl",
        32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}), 32'd0);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_id_ex_stage.md
Name: mips_id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined MIPS core; sits directly upstream of the EX-stage ALU and drives its ALUctrl, in1 and in2 inputs.
- Captures decoded operands and control each cycle, decodes ALUop/funct into the 4-bit ALU control code, and applies stall and flush.
- Resolves EX/MEM and MEM/WB data hazards by forwarding into the ALU operands.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all registered contents.
- flush  in  1  replace the next stage contents with a bubble.
- id_valid  in  1  ID stage holds a real instruction.
- id_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate.
- id_funct  in  6  instruction funct field.
- id_shamt  in  5  shift amount.
- id_rs, id_rt, id_rd  in  RW each  source and destination register indices.
- id_rs_data, id_rt_data  in  DW each  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_alusrc  in  1  in2 takes the immediate.
- id_regdst  in  1  destination is rd (1) or rt (0).
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch  in  1 each  control bits.
- exmem_regwrite  in  1, exmem_rd  in  RW, exmem_result  in  DW  EX/MEM forwarding source.
- memwb_regwrite  in  1, memwb_rd  in  RW, memwb_result  in  DW  MEM/WB forwarding source.
- ex_valid  out  1  EX stage holds a real instruction.
- ex_aluctrl  out  4  ALU control code.
- ex_in1, ex_in2  out  DW each  ALU operands.
- ex_store_data  out  DW  forwarded rt value for stores.
- ex_dest  out  RW  destination register index.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  1 each  registered control bits.
- ex_illegal  out  1  unsupported funct decoded.

Behaviour:
- Latency: one cycle from ID inputs to the registered EX state. ex_in1, ex_in2 and ex_store_data are combinational from the registered state plus the forwarding inputs.
- Reset (asynchronous, rst=1):
  - All registered data is 0.
  - ex_valid=0, every control bit=0, ex_dest=0, ex_illegal=0.
  - ex_aluctrl=15 (NOP code; the ALU outputs 0).
- Priority each edge: rst > flush > stall > load.
  - flush=1 loads a bubble, identical to the reset state, even when stall=1.
  - stall=1 holds every register unchanged.
  - Otherwise all fields load from the ID inputs.
- Bubble on invalid input: when loading with id_valid=0, the control bits load as 0 and ex_aluctrl loads as 15.
- ALU control decode:
  - aluop 00 -> 2 (ADD).
  - aluop 01 -> 6 (SUB).
  - aluop 11 -> 1 (OR).
  - aluop 10, by funct:
    - 0x20 -> 2 (ADD); 0x22 -> 6 (SUB).
    - 0x24 -> 0 (AND); 0x25 -> 1 (OR); 0x27 -> 12 (NOR).
    - 0x2A -> 7 (SLT); 0x00 -> 3 (SLL).
    - Any other funct -> 15, and ex_illegal=1 (only when id_valid=1).
- Destination: ex_dest = id_regdst ? id_rd : id_rt.
- Operand A source (fwdA):
  - EX/MEM when exmem_regwrite=1, exmem_rd != 0 and exmem_rd equals the registered rs.
  - Else MEM/WB under the same conditions using memwb_regwrite and memwb_rd.
  - Else the registered rs data.
  - EX/MEM wins whenever both sources match.
- Operand B source (fwdB): same rules on the registered rt.
- Operand muxing:
  - SLL: ex_in1 = fwdB value; ex_in2 = shamt zero-extended to DW.
  - Otherwise: ex_in1 = fwdA value; ex_in2 = registered alusrc ? imm : fwdB value.
  - ex_store_data = fwdB value.
- Register 0 is never forwarded. A bubble's outputs still evaluate but have no effect.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined: forwarding exactly as specified under Behaviour.
- Undefined: fwdA and fwdB are always the registered rs and rt data; the exmem_* and memwb_* ports remain present and are ignored; hazards are then left to the hazard/stall unit.

Decomposition:
- Package mips_pkg holds:
  - ALU control constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_NOP=15.
  - Funct constants.
  - ALUop encodings.
  - Forwarding-select enum: FWD_REG, FWD_MEMWB, FWD_EXMEM.
- One sub-module: mips_alu_ctrl, a combinational decoder from (aluop, funct) to (aluctrl, illegal). It is reusable by the hazard unit.

Test Plan:
- Reset: assert rst mid-cycle with valid data loaded -> ex_valid=0 and ex_aluctrl=15 immediately, without waiting for a clock edge; all other outputs 0.
- R-type decode: aluop=10 with funct 0x20, 0x22, 0x24, 0x25, 0x27, 0x2A, 0x00, 0x3F -> ex_aluctrl 2, 6, 0, 1, 12, 7, 3, 15 one cycle later; ex_illegal=1 only for 0x3F.
- Forwarding priority: rs=8, id_rs_data=5, exmem_rd=8 with result 0x11, memwb_rd=8 with result 0x22, both regwrite=1 -> ex_in1=0x11. Drop exmem_regwrite -> ex_in1=0x22. Set rs=0 -> ex_in1=5.
- Stall then flush: load ADD 8+10, then stall=1 for 2 cycles -> outputs held, ex_in1=8, ex_in2=10. Then stall=1 and flush=1 together -> bubble: ex_valid=0, ex_aluctrl=15.
- SLL and immediate: funct=0x00, shamt=5, rt data=5 -> ex_in1=5, ex_in2=5, ex_aluctrl=3. Then aluop=00, alusrc=1, imm=-4 -> ex_in2=0xFFFFFFFC, ex_aluctrl=2.
- Build without IDEX_FORWARD_EN: the forwarding-priority stimulus -> ex_in1=5 in all three cases.
